// File: rtl/axi_txn_gate_static_pkg.sv
// ----------------------------------------------------------------------------
// axi_txn_gate_static_pkg
//   Shared definitions for the dynamic/static boundary transaction gate:
//   default AXI widths, the shell-wide outstanding-burst default, the
//   counter-width helper and the counter update encoding used by the gate.
// ----------------------------------------------------------------------------
package axi_txn_gate_static_pkg;

    // Shell-wide AXI geometry defaults.
    localparam int AXI_ID_BITS       = 6;
    localparam int AXI_ADDR_BITS     = 64;
    localparam int AXI_DATA_BITS     = 512;

    // Shell-wide default for in-flight bursts per direction.
    localparam int N_OUTSTANDING_DEF = 16;

    // Width needed to hold every value 0..n inclusive.
    function automatic int cnt_bits(input int n);
        return $clog2(n + 1);
    endfunction

    // What the outstanding counter does on a given cycle.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/axi_txn_gate_static_cnt_gate.sv
// ----------------------------------------------------------------------------
// axi_txn_cnt_gate
//   Outstanding-burst counter plus address-channel gate for one direction
//   (read or write) of the boundary stage.
//
//   Ports:
//     aclk, aresetn : clock, synchronous active-low reset
//     req_valid     : upstream address valid (before gating)
//     req_ready     : downstream address ready (before gating)
//     done          : one burst completed this cycle (R last beat or B)
//     drain         : block new requests while high
//     open          : gate open; gated valid/ready = raw & open
//     count         : registered in-flight burst count
//     idle          : nothing in flight, nothing presented, no handshake now
// ----------------------------------------------------------------------------
module axi_txn_cnt_gate
    import axi_txn_gate_static_pkg::*;
#(
    parameter int N_OUTSTANDING = N_OUTSTANDING_DEF,
    parameter int CNT_BITS      = cnt_bits(N_OUTSTANDING)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                req_valid,
    input  logic                req_ready,
    input  logic                done,
    input  logic                drain,
    output logic                open,
    output logic [CNT_BITS-1:0] count,
    output logic                idle
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(N_OUTSTANDING);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                lock_q, lock_d;
    logic                below_max;
    logic                req_fire;
    logic                inc_ok;
    logic                dec_ok;
    cnt_op_e             cnt_op;

    // The limit uses the registered count, so a completion in this cycle
    // only reopens the gate on the following cycle.
    assign below_max = (cnt_q < CNT_MAX);

    // Once a valid has been presented downstream it must stay up until the
    // handshake, so the lock overrides both drain and the limit.
    assign open     = lock_q | (!drain & below_max);
    assign req_fire = req_valid & open & req_ready;

    always_comb begin
        lock_d = lock_q;
        if (req_fire) begin
            lock_d = 1'b0;
        end else if (req_valid & open) begin
            // Presented downstream but not taken: hold it open.
            lock_d = 1'b1;
        end
    end

    // Saturate at the limit and ignore completions with nothing in flight;
    // both are upstream protocol violations and must not wrap the count.
    assign inc_ok = req_fire & below_max;
    assign dec_ok = done & (cnt_q != '0);

    always_comb begin
        cnt_op = CNT_HOLD;
        if (inc_ok && !dec_ok) begin
            cnt_op = CNT_INC;
        end else if (dec_ok && !inc_ok) begin
            cnt_op = CNT_DEC;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case (cnt_op)
            CNT_INC: cnt_d = cnt_q + CNT_ONE;
            CNT_DEC: cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    assign count = cnt_q;
    assign idle  = (cnt_q == '0) & !lock_q & !req_fire;

endmodule

// File: rtl/axi_txn_gate_static.sv
// ----------------------------------------------------------------------------
// axi_txn_gate_static
//   AXI4 pass-through stage at the dynamic/static boundary. Limits in-flight
//   read and write bursts to N_OUTSTANDING each and offers a drain handshake
//   so the shell can quiesce the link before decoupling the region.
//   W, R, B and all address payload fields pass through with zero latency;
//   only AR/AW valid and ready are gated.
//
//   Ports:
//     aclk, aresetn        : clock, synchronous active-low reset
//     s_axi_*              : upstream AXI4 slave port (from the dynamic region)
//     m_axi_*              : downstream AXI4 master port (to the register slices)
//     drain_req            : level, blocks new AR/AW while high
//     drained              : registered, link fully quiescent under drain_req
//     rd_outstanding       : registered in-flight read bursts
//     wr_outstanding       : registered in-flight write bursts
// ----------------------------------------------------------------------------
module axi_txn_gate_static
    import axi_txn_gate_static_pkg::*;
#(
    parameter  int ID_BITS       = AXI_ID_BITS,
    parameter  int ADDR_BITS     = AXI_ADDR_BITS,
    parameter  int DATA_BITS     = AXI_DATA_BITS,
    parameter  int N_OUTSTANDING = N_OUTSTANDING_DEF,
    localparam int CNT_BITS      = cnt_bits(N_OUTSTANDING),
    localparam int STRB_BITS     = DATA_BITS / 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,

    // Upstream AW
    input  logic [ID_BITS-1:0]   s_axi_awid,
    input  logic [ADDR_BITS-1:0] s_axi_awaddr,
    input  logic [7:0]           s_axi_awlen,
    input  logic [2:0]           s_axi_awsize,
    input  logic [1:0]           s_axi_awburst,
    input  logic                 s_axi_awlock,
    input  logic [3:0]           s_axi_awcache,
    input  logic [2:0]           s_axi_awprot,
    input  logic [3:0]           s_axi_awqos,
    input  logic [3:0]           s_axi_awregion,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    // Upstream W
    input  logic [DATA_BITS-1:0] s_axi_wdata,
    input  logic [STRB_BITS-1:0] s_axi_wstrb,
    input  logic                 s_axi_wlast,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    // Upstream B
    output logic [ID_BITS-1:0]   s_axi_bid,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    // Upstream AR
    input  logic [ID_BITS-1:0]   s_axi_arid,
    input  logic [ADDR_BITS-1:0] s_axi_araddr,
    input  logic [7:0]           s_axi_arlen,
    input  logic [2:0]           s_axi_arsize,
    input  logic [1:0]           s_axi_arburst,
    input  logic                 s_axi_arlock,
    input  logic [3:0]           s_axi_arcache,
    input  logic [2:0]           s_axi_arprot,
    input  logic [3:0]           s_axi_arqos,
    input  logic [3:0]           s_axi_arregion,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    // Upstream R
    output logic [ID_BITS-1:0]   s_axi_rid,
    output logic [DATA_BITS-1:0] s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rlast,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,

    // Downstream AW
    output logic [ID_BITS-1:0]   m_axi_awid,
    output logic [ADDR_BITS-1:0] m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    output logic                 m_axi_awlock,
    output logic [3:0]           m_axi_awcache,
    output logic [2:0]           m_axi_awprot,
    output logic [3:0]           m_axi_awqos,
    output logic [3:0]           m_axi_awregion,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    // Downstream W
    output logic [DATA_BITS-1:0] m_axi_wdata,
    output logic [STRB_BITS-1:0] m_axi_wstrb,
    output logic                 m_axi_wlast,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    // Downstream B
    input  logic [ID_BITS-1:0]   m_axi_bid,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    // Downstream AR
    output logic [ID_BITS-1:0]   m_axi_arid,
    output logic [ADDR_BITS-1:0] m_axi_araddr,
    output logic [7:0]           m_axi_arlen,
    output logic [2:0]           m_axi_arsize,
    output logic [1:0]           m_axi_arburst,
    output logic                 m_axi_arlock,
    output logic [3:0]           m_axi_arcache,
    output logic [2:0]           m_axi_arprot,
    output logic [3:0]           m_axi_arqos,
    output logic [3:0]           m_axi_arregion,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    // Downstream R
    input  logic [ID_BITS-1:0]   m_axi_rid,
    input  logic [DATA_BITS-1:0] m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rlast,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready,

    // Drain / status
    input  logic                 drain_req,
    output logic                 drained,
    output logic [CNT_BITS-1:0]  rd_outstanding,
    output logic [CNT_BITS-1:0]  wr_outstanding
);

    logic ar_open, aw_open;
    logic rd_idle, wr_idle;
    logic rd_done, wr_done;
    logic drained_q, drained_d;

    // ------------------------------------------------------------------
    // Address payload: straight through.
    // ------------------------------------------------------------------
    assign m_axi_awid     = s_axi_awid;
    assign m_axi_awaddr   = s_axi_awaddr;
    assign m_axi_awlen    = s_axi_awlen;
    assign m_axi_awsize   = s_axi_awsize;
    assign m_axi_awburst  = s_axi_awburst;
    assign m_axi_awlock   = s_axi_awlock;
    assign m_axi_awcache  = s_axi_awcache;
    assign m_axi_awprot   = s_axi_awprot;
    assign m_axi_awqos    = s_axi_awqos;
    assign m_axi_awregion = s_axi_awregion;

    assign m_axi_arid     = s_axi_arid;
    assign m_axi_araddr   = s_axi_araddr;
    assign m_axi_arlen    = s_axi_arlen;
    assign m_axi_arsize   = s_axi_arsize;
    assign m_axi_arburst  = s_axi_arburst;
    assign m_axi_arlock   = s_axi_arlock;
    assign m_axi_arcache  = s_axi_arcache;
    assign m_axi_arprot   = s_axi_arprot;
    assign m_axi_arqos    = s_axi_arqos;
    assign m_axi_arregion = s_axi_arregion;

    // ------------------------------------------------------------------
    // Data and response channels: straight through. W is deliberately not
    // gated; write data may lead AW and the downstream slices buffer it.
    // ------------------------------------------------------------------
    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_wstrb  = s_axi_wstrb;
    assign m_axi_wlast  = s_axi_wlast;
    assign m_axi_wvalid = s_axi_wvalid;
    assign s_axi_wready = m_axi_wready;

    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;

    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;

    // ------------------------------------------------------------------
    // Address gating.
    // ------------------------------------------------------------------
    assign m_axi_arvalid = s_axi_arvalid & ar_open;
    assign s_axi_arready = m_axi_arready & ar_open;
    assign m_axi_awvalid = s_axi_awvalid & aw_open;
    assign s_axi_awready = m_axi_awready & aw_open;

    // A read burst completes on its last R beat; a write burst on its B.
    assign rd_done = m_axi_rvalid & s_axi_rready & m_axi_rlast;
    assign wr_done = m_axi_bvalid & s_axi_bready;

    axi_txn_cnt_gate #(
        .N_OUTSTANDING (N_OUTSTANDING),
        .CNT_BITS      (CNT_BITS)
    ) u_rd_gate (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (s_axi_arvalid),
        .req_ready (m_axi_arready),
        .done      (rd_done),
        .drain     (drain_req),
        .open      (ar_open),
        .count     (rd_outstanding),
        .idle      (rd_idle)
    );

    axi_txn_cnt_gate #(
        .N_OUTSTANDING (N_OUTSTANDING),
        .CNT_BITS      (CNT_BITS)
    ) u_wr_gate (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (s_axi_awvalid),
        .req_ready (m_axi_awready),
        .done      (wr_done),
        .drain     (drain_req),
        .open      (aw_open),
        .count     (wr_outstanding),
        .idle      (wr_idle)
    );

    // ------------------------------------------------------------------
    // Drain status. Registered, so it lags the last completion by one
    // cycle and drops one cycle after drain_req is released.
    // ------------------------------------------------------------------
    assign drained_d = drain_req & rd_idle & wr_idle;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            drained_q <= 1'b0;
        end else begin
            drained_q <= drained_d;
        end
    end

    assign drained = drained_q;

endmodule

// File: tb/tb_axi_txn_gate_static.sv
module tb_axi_txn_gate_static;

    localparam int IDB = 4;
    localparam int AB  = 32;
    localparam int DB  = 32;
    localparam int SB  = DB / 8;
    localparam int N   = 4;
    localparam int CB  = 3;

    logic aclk, aresetn;

    logic [IDB-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
    logic [AB-1:0]  s_axi_awaddr, s_axi_araddr;
    logic [7:0]     s_axi_awlen, s_axi_arlen;
    logic [2:0]     s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
    logic [1:0]     s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic           s_axi_awlock, s_axi_arlock;
    logic [3:0]     s_axi_awcache, s_axi_arcache, s_axi_awqos, s_axi_arqos;
    logic [3:0]     s_axi_awregion, s_axi_arregion;
    logic           s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
    logic [DB-1:0]  s_axi_wdata, s_axi_rdata;
    logic [SB-1:0]  s_axi_wstrb;
    logic           s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic           s_axi_bvalid, s_axi_bready;
    logic           s_axi_rlast, s_axi_rvalid, s_axi_rready;

    logic [IDB-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [AB-1:0]  m_axi_awaddr, m_axi_araddr;
    logic [7:0]     m_axi_awlen, m_axi_arlen;
    logic [2:0]     m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]     m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic           m_axi_awlock, m_axi_arlock;
    logic [3:0]     m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
    logic [3:0]     m_axi_awregion, m_axi_arregion;
    logic           m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [DB-1:0]  m_axi_wdata, m_axi_rdata;
    logic [SB-1:0]  m_axi_wstrb;
    logic           m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic           m_axi_bvalid, m_axi_bready;
    logic           m_axi_rlast, m_axi_rvalid, m_axi_rready;

    logic           drain_req, drained;
    logic [CB-1:0]  rd_outstanding, wr_outstanding;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboards: address {id,addr}, R {id,data}, B {id,resp}.
    logic [IDB+AB-1:0] ar_q[$];
    logic [IDB+AB-1:0] aw_q[$];
    logic [IDB+DB-1:0] r_q[$];
    logic [IDB+1:0]    b_q[$];
    logic [IDB+AB-1:0] exp_ar, exp_aw;
    logic [IDB+DB-1:0] exp_r;
    logic [IDB+1:0]    exp_b;

    axi_txn_gate_static #(
        .ID_BITS       (IDB),
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB),
        .N_OUTSTANDING (N)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axi_awid     (s_axi_awid),
        .s_axi_awaddr   (s_axi_awaddr),
        .s_axi_awlen    (s_axi_awlen),
        .s_axi_awsize   (s_axi_awsize),
        .s_axi_awburst  (s_axi_awburst),
        .s_axi_awlock   (s_axi_awlock),
        .s_axi_awcache  (s_axi_awcache),
        .s_axi_awprot   (s_axi_awprot),
        .s_axi_awqos    (s_axi_awqos),
        .s_axi_awregion (s_axi_awregion),
        .s_axi_awvalid  (s_axi_awvalid),
        .s_axi_awready  (s_axi_awready),
        .s_axi_wdata    (s_axi_wdata),
        .s_axi_wstrb    (s_axi_wstrb),
        .s_axi_wlast    (s_axi_wlast),
        .s_axi_wvalid   (s_axi_wvalid),
        .s_axi_wready   (s_axi_wready),
        .s_axi_bid      (s_axi_bid),
        .s_axi_bresp    (s_axi_bresp),
        .s_axi_bvalid   (s_axi_bvalid),
        .s_axi_bready   (s_axi_bready),
        .s_axi_arid     (s_axi_arid),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arlen    (s_axi_arlen),
        .s_axi_arsize   (s_axi_arsize),
        .s_axi_arburst  (s_axi_arburst),
        .s_axi_arlock   (s_axi_arlock),
        .s_axi_arcache  (s_axi_arcache),
        .s_axi_arprot   (s_axi_arprot),
        .s_axi_arqos    (s_axi_arqos),
        .s_axi_arregion (s_axi_arregion),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_rid      (s_axi_rid),
        .s_axi_rdata    (s_axi_rdata),
        .s_axi_rresp    (s_axi_rresp),
        .s_axi_rlast    (s_axi_rlast),
        .s_axi_rvalid   (s_axi_rvalid),
        .s_axi_rready   (s_axi_rready),
        .m_axi_awid     (m_axi_awid),
        .m_axi_awaddr   (m_axi_awaddr),
        .m_axi_awlen    (m_axi_awlen),
        .m_axi_awsize   (m_axi_awsize),
        .m_axi_awburst  (m_axi_awburst),
        .m_axi_awlock   (m_axi_awlock),
        .m_axi_awcache  (m_axi_awcache),
        .m_axi_awprot   (m_axi_awprot),
        .m_axi_awqos    (m_axi_awqos),
        .m_axi_awregion (m_axi_awregion),
        .m_axi_awvalid  (m_axi_awvalid),
        .m_axi_awready  (m_axi_awready),
        .m_axi_wdata    (m_axi_wdata),
        .m_axi_wstrb    (m_axi_wstrb),
        .m_axi_wlast    (m_axi_wlast),
        .m_axi_wvalid   (m_axi_wvalid),
        .m_axi_wready   (m_axi_wready),
        .m_axi_bid      (m_axi_bid),
        .m_axi_bresp    (m_axi_bresp),
        .m_axi_bvalid   (m_axi_bvalid),
        .m_axi_bready   (m_axi_bready),
        .m_axi_arid     (m_axi_arid),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arlock   (m_axi_arlock),
        .m_axi_arcache  (m_axi_arcache),
        .m_axi_arprot   (m_axi_arprot),
        .m_axi_arqos    (m_axi_arqos),
        .m_axi_arregion (m_axi_arregion),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_rid      (m_axi_rid),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .drain_req      (drain_req),
        .drained        (drained),
        .rd_outstanding (rd_outstanding),
        .wr_outstanding (wr_outstanding)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_ar(input logic [IDB-1:0] id, input logic [AB-1:0] addr);
        s_axi_arvalid = 1'b1;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        ar_q.push_back({id, addr});
    endtask

    task automatic drive_aw(input logic [IDB-1:0] id, input logic [AB-1:0] addr);
        s_axi_awvalid = 1'b1;
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        aw_q.push_back({id, addr});
    endtask

    task automatic drive_r(input logic [IDB-1:0] id, input logic [DB-1:0] data, input logic last);
        m_axi_rvalid = 1'b1;
        m_axi_rid    = id;
        m_axi_rdata  = data;
        m_axi_rlast  = last;
        r_q.push_back({id, data});
    endtask

    task automatic drive_b(input logic [IDB-1:0] id, input logic [1:0] resp);
        m_axi_bvalid = 1'b1;
        m_axi_bid    = id;
        m_axi_bresp  = resp;
        b_q.push_back({id, resp});
    endtask

    // Output monitors sample mid-cycle; inputs only change just after posedge.
    always @(negedge aclk) begin
        if (m_axi_arvalid && m_axi_arready) begin
            if (ar_q.size() == 0) begin
                check("ar_unexpected", 64'd1, 64'd0);
            end else begin
                exp_ar = ar_q.pop_front();
                check("ar_payload", {m_axi_arid, m_axi_araddr}, exp_ar);
                $display("AR  id=%0d addr=0x%08h len=%0d", m_axi_arid, m_axi_araddr, m_axi_arlen);
            end
        end
        if (m_axi_awvalid && m_axi_awready) begin
            if (aw_q.size() == 0) begin
                check("aw_unexpected", 64'd1, 64'd0);
            end else begin
                exp_aw = aw_q.pop_front();
                check("aw_payload", {m_axi_awid, m_axi_awaddr}, exp_aw);
                $display("AW  id=%0d addr=0x%08h", m_axi_awid, m_axi_awaddr);
            end
        end
        if (s_axi_rvalid && s_axi_rready) begin
            if (r_q.size() == 0) begin
                check("r_unexpected", 64'd1, 64'd0);
            end else begin
                exp_r = r_q.pop_front();
                check("r_payload", {s_axi_rid, s_axi_rdata}, exp_r);
                $display("R   id=%0d data=0x%08h last=%0b", s_axi_rid, s_axi_rdata, s_axi_rlast);
            end
        end
        if (s_axi_bvalid && s_axi_bready) begin
            if (b_q.size() == 0) begin
                check("b_unexpected", 64'd1, 64'd0);
            end else begin
                exp_b = b_q.pop_front();
                check("b_payload", {s_axi_bid, s_axi_bresp}, exp_b);
                $display("B   id=%0d resp=%0d", s_axi_bid, s_axi_bresp);
            end
        end
    end

    initial begin
        aresetn = 1'b0;
        drain_req = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = 8'd3; s_axi_awsize = 3'd2;
        s_axi_awburst = 2'b01; s_axi_awlock = 1'b0; s_axi_awcache = 4'h3; s_axi_awprot = 3'd0;
        s_axi_awqos = 4'h0; s_axi_awregion = 4'h0; s_axi_awvalid = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = 8'd7; s_axi_arsize = 3'd2;
        s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arcache = 4'h3; s_axi_arprot = 3'd0;
        s_axi_arqos = 4'h0; s_axi_arregion = 4'h0; s_axi_arvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        m_axi_awready = 1'b1; m_axi_arready = 1'b1; m_axi_wready = 1'b1;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

        // Reset state; gates are combinationally open even under reset.
        tick();
        check("rst_rd_cnt", rd_outstanding, 0);
        check("rst_wr_cnt", wr_outstanding, 0);
        check("rst_drained", drained, 0);
        check("rst_ar_open", s_axi_arready, 1);
        check("rst_aw_open", s_axi_awready, 1);
        tick();
        aresetn = 1'b1;
        tick();

        // Four back-to-back reads fill the budget; the fifth is held off.
        for (int i = 0; i < 4; i++) begin
            drive_ar(4'(i), 32'h1000 + 32'(i * 64));
            #1 check("ar_accept", s_axi_arready, 1);
            tick();
        end
        drive_ar(4'd5, 32'h2000);
        #1;
        check("ar_full_ready", s_axi_arready, 0);
        check("ar_full_valid", m_axi_arvalid, 0);
        check("rd_cnt_full", rd_outstanding, 4);

        // One completion: the count drops next cycle, the fifth AR goes then.
        drive_r(4'd0, 32'hCAFE0001, 1'b1);
        #1 check("ar_no_same_cycle_reopen", s_axi_arready, 0);
        tick();
        m_axi_rvalid = 1'b0;
        #1;
        check("rd_cnt_after_r", rd_outstanding, 3);
        check("ar_reopen", s_axi_arready, 1);
        tick();
        s_axi_arvalid = 1'b0;
        #1 check("rd_cnt_refill", rd_outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            drive_r(4'(i + 1), 32'hBEEF0000 + 32'(i), 1'b1);
            tick();
        end
        m_axi_rvalid = 1'b0;
        #1 check("rd_cnt_empty", rd_outstanding, 0);

        // Writes: reach 2, then simultaneous AW and B leaves it at 2.
        for (int i = 0; i < 2; i++) begin
            drive_aw(4'(i), 32'h8000 + 32'(i * 256));
            tick();
        end
        s_axi_awvalid = 1'b0;
        #1 check("wr_cnt_two", wr_outstanding, 2);
        drive_aw(4'd2, 32'h8200);
        drive_b(4'd0, 2'b00);
        #1 check("aw_open_at_two", s_axi_awready, 1);
        tick();
        s_axi_awvalid = 1'b0;
        m_axi_bvalid = 1'b0;
        #1 check("wr_cnt_inc_dec", wr_outstanding, 2);
        drive_aw(4'd3, 32'h8300);
        #1 check("aw_still_open", s_axi_awready, 1);
        tick();
        s_axi_awvalid = 1'b0;
        #1 check("wr_cnt_three", wr_outstanding, 3);
        // W is ungated and passes straight through.
        s_axi_wvalid = 1'b1;
        s_axi_wdata  = 32'h5A5A1234;
        s_axi_wstrb  = 4'hF;
        #1;
        check("w_data", m_axi_wdata, 32'h5A5A1234);
        check("w_valid", m_axi_wvalid, 1);
        s_axi_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_b(4'(i + 1), 2'(i));
            tick();
        end
        m_axi_bvalid = 1'b0;
        #1 check("wr_cnt_empty", wr_outstanding, 0);

        // A stalled AR survives drain_req; the next one is blocked.
        m_axi_arready = 1'b0;
        drive_ar(4'd7, 32'h3000);
        #1 check("ar_stall_valid", m_axi_arvalid, 1);
        tick();
        drain_req = 1'b1;
        #1;
        check("ar_lock_hold", m_axi_arvalid, 1);
        check("ar_lock_noready", s_axi_arready, 0);
        tick();
        check("ar_lock_hold2", m_axi_arvalid, 1);
        m_axi_arready = 1'b1;
        #1 check("ar_lock_hs", s_axi_arready, 1);
        tick();
        s_axi_araddr = 32'h3040;
        #1;
        check("ar_drain_block_v", m_axi_arvalid, 0);
        check("ar_drain_block_r", s_axi_arready, 0);
        check("rd_cnt_locked_one", rd_outstanding, 1);
        s_axi_arvalid = 1'b0;

        // Drain with 2 reads and 1 write in flight.
        drain_req = 1'b0;
        drive_ar(4'd8, 32'h4000);
        tick();
        s_axi_arvalid = 1'b0;
        drive_aw(4'd9, 32'h9000);
        tick();
        s_axi_awvalid = 1'b0;
        #1;
        check("drain_rd_two", rd_outstanding, 2);
        check("drain_wr_one", wr_outstanding, 1);
        drain_req = 1'b1;
        tick();
        check("drained_busy", drained, 0);
        drive_r(4'd7, 32'h11110000, 1'b0);
        tick();
        check("rd_cnt_nonlast", rd_outstanding, 2);
        drive_r(4'd7, 32'h11110001, 1'b1);
        tick();
        m_axi_rvalid = 1'b0;
        check("drain_rd_one", rd_outstanding, 1);
        check("drained_rd_left", drained, 0);
        drive_b(4'd9, 2'b00);
        tick();
        m_axi_bvalid = 1'b0;
        check("drain_wr_zero", wr_outstanding, 0);
        check("drained_rd_left2", drained, 0);
        drive_r(4'd8, 32'h22220001, 1'b1);
        tick();
        m_axi_rvalid = 1'b0;
        check("drain_rd_zero", rd_outstanding, 0);
        check("drained_lag", drained, 0);
        tick();
        check("drained_set", drained, 1);
        drain_req = 1'b0;
        tick();
        check("drained_clear", drained, 0);

        // Completions with nothing in flight must not wrap.
        drive_r(4'd1, 32'hDEAD0000, 1'b1);
        drive_b(4'd1, 2'b10);
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_bvalid = 1'b0;
        #1;
        check("rd_cnt_no_underflow", rd_outstanding, 0);
        check("wr_cnt_no_underflow", wr_outstanding, 0);

        // Reset with three reads in flight.
        for (int i = 0; i < 3; i++) begin
            drive_ar(4'(i + 10), 32'h5000 + 32'(i * 64));
            tick();
        end
        s_axi_arvalid = 1'b0;
        #1 check("rd_cnt_three", rd_outstanding, 3);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        #1;
        check("rst2_rd_cnt", rd_outstanding, 0);
        check("rst2_drained", drained, 0);
        drive_ar(4'd13, 32'h6000);
        #1 check("rst2_ar_open", s_axi_arready, 1);
        tick();
        s_axi_arvalid = 1'b0;
        #1 check("rst2_rd_cnt_one", rd_outstanding, 1);

        tick();
        check("ar_sb_left", ar_q.size(), 0);
        check("aw_sb_left", aw_q.size(), 0);
        check("r_sb_left", r_q.size(), 0);
        check("b_sb_left", b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_txn_gate_static.md
Name: axi_txn_gate_static

Overview:
- Full AXI4 pass-through stage placed in front of the static-region AXI register-slice chain, at the dynamic/static boundary.
- Limits outstanding read and write transactions to N_OUTSTANDING each.
- Provides a drain handshake so the shell can quiesce the interface before decoupling or reconfiguring the region.
- All data and response channels pass through combinationally. Only the AR and AW channels are gated.

Parameters:
- ID_BITS, AXI_ID_BITS: AXI ID width of both interfaces.
- N_OUTSTANDING, 16: maximum in-flight read bursts, and separately maximum in-flight write bursts. Legal range is 1..256.
- CNT_BITS, $clog2(N_OUTSTANDING+1): derived localparam giving the counter width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axi  AXI4.s  ID_BITS  upstream (master side) interface
- m_axi  AXI4.m  ID_BITS  downstream interface toward the register slices
- drain_req  in  1  level; when high, no new AR/AW is accepted
- drained  out  1  registered; high when the interface is fully quiescent
- rd_outstanding  out  CNT_BITS  current in-flight read bursts (registered)
- wr_outstanding  out  CNT_BITS  current in-flight write bursts (registered)

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - rd_cnt=0, wr_cnt=0, ar_lock=0, aw_lock=0, drained=0.
  - Combinational gating still applies during reset. With counts at 0 and drain_req=0, both gates are open.
- Pass-through: W, R and B, plus all AR/AW payload fields, are wired straight through with zero cycles of latency.
- AR gate:
  - ar_open = ar_lock | (!drain_req & rd_cnt < N_OUTSTANDING).
  - m_axi.arvalid = s_axi.arvalid & ar_open.
  - s_axi.arready = m_axi.arready & ar_open.
- AW gate: identical to the AR gate, using wr_cnt and aw_lock.
- Valid stability (AXI rule: a presented valid must not drop):
  - ar_lock sets when m_axi.arvalid=1 and m_axi.arready=0.
  - ar_lock clears on the AR handshake.
  - While ar_lock=1, drain_req cannot retract arvalid.
  - aw_lock works the same way.
- rd_cnt update:
  - Increments on the m_axi AR handshake.
  - Decrements on the R handshake when s_axi.rlast=1.
  - Both in the same cycle: unchanged.
- wr_cnt update:
  - Increments on the m_axi AW handshake.
  - Decrements on the B handshake.
  - Both in the same cycle: unchanged.
- Counter semantics:
  - Counts take effect the cycle after the handshake.
  - The limit check uses the registered count, so at count=N-1 exactly one more request is accepted.
  - A decrement in the same cycle does not reopen the gate until the next cycle.
- Counter boundaries (protocol-violation cases):
  - Counter saturates at N_OUTSTANDING, with no wrap.
  - Decrement at 0 is ignored; rlast/B with no outstanding burst is an upstream violation.
- W channel is not gated. Write data may lead AW; the downstream side is responsible for buffering it.
- drained <= drain_req & rd_cnt==0 & wr_cnt==0 & !ar_lock & !aw_lock & no AR/AW handshake this cycle.
  - drained drops the cycle after drain_req deasserts.
- drain_req asserted mid-burst: outstanding bursts complete normally, and drained rises once the last rlast/B completes.
- Reset during traffic: counters and locks clear immediately. The upstream and downstream sides must be reset together.

Decomposition:
- The lynxTypes package already provides AXI_ID_BITS. Add N_OUTSTANDING_DEF=16 to that package as the shell-wide default.
- Natural sub-module: axi_txn_cnt_gate, instantiated twice (read and write).
  - Inputs: req valid/ready, done pulse, drain.
  - Outputs: open, count, idle.
  - Contains the counter and the lock.

Test Plan (N_OUTSTANDING=4):
- 4 back-to-back ARs with arready=1 and no R traffic → all 4 accepted; 5th s_axi.arready=0; rd_outstanding=4.
- From rd_cnt=4, a single R beat with rlast=1 → rd_outstanding=3 next cycle; the pending 5th AR is accepted one cycle later.
- Simultaneous AW handshake and B handshake at wr_cnt=2 → wr_outstanding stays at 2; gate stays open.
- AR presented with arready=0, then drain_req raised → m_axi.arvalid stays 1 until arready; that handshake completes; the next AR is blocked.
- drain_req=1 with 2 reads and 1 write outstanding → drained=0 until the last rlast and B complete; drained=1 one cycle later; drain_req=0 → drained=0 next cycle.
- aresetn=0 for 1 cycle at rd_cnt=3 → rd_outstanding=0, drained=0, AR gate open afterwards.
